// File: rtl/spi_hex_target.sv
// SPI mode-0 target that writes eight 8-bit digit registers and drives HEX0..HEX7.
// Define SPI_HEX_READBACK_EN to compile in register readback over MISO.
`timescale 1ns/1ps
module spi_hex_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic [6:0] hex6,
  output logic [6:0] hex7,
  output logic       wr_pulse,
  output logic [2:0] wr_addr
);

`ifdef SPI_HEX_READBACK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA} state_t;
  localparam state_t ST_READ = ST_RDATA;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WDATA, ST_DISCARD} state_t;
  localparam state_t ST_READ = ST_DISCARD;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_reg, mosi_sync_reg, cs_sync_reg;
  logic                   sclk_d_reg, cs_d_reg;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign cs_rise   = cs_s & ~cs_d_reg;
  assign cs_fall   = ~cs_s & cs_d_reg;

  // cs_n chain resets low: a frame already running at reset release shows no falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      cs_sync_reg   <= '0;
      sclk_d_reg    <= 1'b0;
      cs_d_reg      <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
      sclk_d_reg    <= sclk_s;
      cs_d_reg      <= cs_s;
    end
  end

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] rx_reg, rx_next;
  logic [2:0] addr_reg, addr_next;
  logic [7:0] byte_in;
  logic       do_write;
  logic       wr_pulse_reg;
  logic [2:0] wr_addr_reg;
  logic [7:0] digit_reg [8];
  logic [6:0] hex_reg [8];
  logic [6:0] hex_next [8];

  assign byte_in = {rx_reg, mosi_s};

`ifdef SPI_HEX_READBACK_EN
  logic       sclk_fall;
  logic [7:0] tx_reg, tx_next;
  logic       miso_reg, miso_next;
  assign sclk_fall = ~sclk_s & sclk_d_reg;
`endif

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    rx_next      = rx_reg;
    addr_next    = addr_reg;
    do_write     = 1'b0;
`ifdef SPI_HEX_READBACK_EN
    tx_next      = tx_reg;
    miso_next    = miso_reg;
`endif
    if (cs_rise) begin
      state_next   = ST_IDLE;
      bit_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cs_fall) begin
            state_next   = ST_CMD;
            bit_cnt_next = '0;
          end
        end
        ST_CMD, ST_WDATA: begin
          if (sclk_rise) begin
            rx_next      = byte_in[6:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (state_reg == ST_CMD) begin
                addr_next  = byte_in[2:0];
                state_next = byte_in[7] ? ST_READ : ST_WDATA;
`ifdef SPI_HEX_READBACK_EN
                tx_next    = digit_reg[byte_in[2:0]];
`endif
              end else begin
                do_write  = 1'b1;
                addr_next = addr_reg + 3'd1;
              end
            end
          end
        end
        ST_READ: begin
          if (sclk_rise) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              addr_next = addr_reg + 3'd1;
`ifdef SPI_HEX_READBACK_EN
              tx_next   = digit_reg[addr_reg + 3'd1];
`endif
            end
`ifdef SPI_HEX_READBACK_EN
          end else if (sclk_fall) begin
            miso_next = tx_reg[7];
            tx_next   = {tx_reg[6:0], 1'b0};
`endif
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
`ifdef SPI_HEX_READBACK_EN
    if (state_next != ST_READ) miso_next = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= '0;
      rx_reg       <= '0;
      addr_reg     <= '0;
      wr_pulse_reg <= 1'b0;
      wr_addr_reg  <= '0;
      for (int i = 0; i < 8; i++) begin
        digit_reg[i] <= 8'h80;
        hex_reg[i]   <= 7'h7F;
      end
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      rx_reg       <= rx_next;
      addr_reg     <= addr_next;
      wr_pulse_reg <= do_write;
      if (do_write) begin
        digit_reg[addr_reg] <= byte_in;
        wr_addr_reg         <= addr_reg;
      end
      for (int i = 0; i < 8; i++) hex_reg[i] <= hex_next[i];
    end
  end

  // Bit7 selects raw segment mode (1 lights a segment) versus hex-digit decode.
  for (genvar gi = 0; gi < 8; gi++) begin : g_decode
    assign hex_next[gi] = digit_reg[gi][7] ? ~digit_reg[gi][6:0]
                                           : seg_decode(digit_reg[gi][3:0]);
  end

`ifdef SPI_HEX_READBACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_reg   <= '0;
      miso_reg <= 1'b0;
    end else begin
      tx_reg   <= tx_next;
      miso_reg <= miso_next;
    end
  end
  assign spi_miso = miso_reg;
`else
  assign spi_miso = 1'b0;
`endif

  assign wr_pulse = wr_pulse_reg;
  assign wr_addr  = wr_addr_reg;
  assign hex0 = hex_reg[0];
  assign hex1 = hex_reg[1];
  assign hex2 = hex_reg[2];
  assign hex3 = hex_reg[3];
  assign hex4 = hex_reg[4];
  assign hex5 = hex_reg[5];
  assign hex6 = hex_reg[6];
  assign hex7 = hex_reg[7];

endmodule
